// File: rtl/nios2_debug_pkg.sv
// rtl/nios2_debug_pkg.sv - shared defaults and command entry type for the Nios II debug command bridge
package nios2_debug_pkg;

    localparam int DEFAULT_DATA_W  = 38;
    localparam int DEFAULT_IR_W    = 2;
    localparam int DEFAULT_ACT_BIT = 37;

    // Queue entry at default widths; the bridge declares an equivalent
    // layout sized by its own parameters.
    typedef struct packed {
        logic [DEFAULT_IR_W-1:0]   ir;
        logic [DEFAULT_DATA_W-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/nios2_debug_cmd_bridge_if.sv
// rtl/nios2_debug_cmd_bridge_if.sv - command output handshake between the bridge and the OCI/break/trace consumer
// Ports (master = bridge): jdo, cmd_ir, cmd_valid, take_action, take_no_action out; cmd_ready in.
interface nios2_debug_cmd_bridge_if #(
    parameter int DATA_W = nios2_debug_pkg::DEFAULT_DATA_W,
    parameter int IR_W   = nios2_debug_pkg::DEFAULT_IR_W
);
    localparam int NUM_CMD = 2 ** IR_W;

    logic [DATA_W-1:0]  jdo;
    logic [IR_W-1:0]    cmd_ir;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [NUM_CMD-1:0] take_action;
    logic [NUM_CMD-1:0] take_no_action;

    modport master (
        output jdo, cmd_ir, cmd_valid, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  jdo, cmd_ir, cmd_valid, take_action, take_no_action,
        output cmd_ready
    );

endinterface

// File: rtl/nios2_debug_sync_edge.sv
// rtl/nios2_debug_sync_edge.sv - multi-flop synchroniser with registered rising-edge pulse
// Ports: clk, reset_n (sync, active low), async_in (foreign-domain level), rise (one-cycle pulse).
module nios2_debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Tracks which synchroniser stages hold real samples since reset, so a
    // level already high at reset release only primes prev_q and never pulses.
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   prev_vld_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '0;
            vld_q      <= '0;
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= sync_q[SYNC_STAGES-1];
            prev_vld_q <= vld_q[SYNC_STAGES-1];
            rise       <= vld_q[SYNC_STAGES-1] & prev_vld_q &
                          sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/nios2_debug_cmd_bridge.sv
// rtl/nios2_debug_cmd_bridge.sv - clk-side Nios II JTAG debug slave: UDR/UIR sync, command FIFO, per-IR decode
// Ports: clk, reset_n, vs_udr, vs_uir, sr, ir_in, clr_ovf in; cmd_if (master) command handshake;
//        ir_upd, fifo_level, overflow, drop_cnt status out.
module nios2_debug_cmd_bridge
    import nios2_debug_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int IR_W        = DEFAULT_IR_W,
    parameter int ACT_BIT     = DEFAULT_ACT_BIT,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        vs_udr,
    input  logic                        vs_uir,
    input  logic [DATA_W-1:0]           sr,
    input  logic [IR_W-1:0]             ir_in,
    input  logic                        clr_ovf,
    nios2_debug_cmd_bridge_if.master    cmd_if,
    output logic                        ir_upd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt
);

    localparam int NUM_CMD = 2 ** IR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic udr_rise;

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (ir_upd)
    );

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic [NUM_CMD-1:0] act_q;
    logic [NUM_CMD-1:0] no_act_q;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign head = mem[rd_ptr];
    assign full = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop  = cmd_if.cmd_valid & cmd_if.cmd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = udr_rise & (~full | pop);
    assign drop = udr_rise & full & ~pop;

    assign cmd_if.cmd_valid      = (level_q != '0);
    assign cmd_if.jdo            = head.data;
    assign cmd_if.cmd_ir         = head.ir;
    assign cmd_if.take_action    = act_q;
    assign cmd_if.take_no_action = no_act_q;
    assign fifo_level            = level_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            act_q    <= '0;
            no_act_q <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{ir: ir_in, data: sr};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);

            act_q    <= '0;
            no_act_q <= '0;
            if (pop) begin
                act_q[head.ir]    <= head.data[ACT_BIT];
                no_act_q[head.ir] <= ~head.data[ACT_BIT];
            end

            // A drop in the same cycle as clr_ovf restarts the count at 1.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule
